tlb_assoc: RTL and testbench
============================

# tlb_assoc

Fully associative, parametrised MIPS32 joint TLB with ASID and global-bit matching, random replacement and the probe/read instructions. Serves one instruction and one data translation port with a registered, one-cycle lookup, and passes kseg0/kseg1 through unmapped. Sits in the MMU between the CP0 (EntryHi/EntryLo/Index/Wired/Random) and the fetch and memory stages.

## Interface

Parameters:
- NUM_ENTRIES, 16: TLB depth, power of two, 4..64. IDX_W = $clog2(NUM_ENTRIES).
- ASID_W, 8: ASID width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- wr_entry  in  tlb_entry_t  entry to write, from CP0 EntryHi/EntryLo0/EntryLo1.
- cur_asid  in  ASID_W  current ASID, from EntryHi.
- index  in  IDX_W  target for tlbwi/tlbr.
- wired  in  IDX_W  CP0 Wired.
- wired_we  in  1  CP0 write to Wired.
- tlbwi, tlbwr, tlbr, tlbp  in  1  instruction strobes, one-hot or zero.
- random  out  IDX_W  CP0 Random value.
- rd_valid  out  1  tlbr result valid. rd_entry  out  tlb_entry_t  entry read.
- prb_valid  out  1  tlbp result valid. prb_miss  out  1  no match. prb_index  out  IDX_W  matching index.
- i_req  in  1  fetch lookup request. i_vaddr  in  32  fetch virtual address.
- i_valid  out  1  fetch result valid. i_paddr  out  32  fetch physical address.
- i_refill  out  1  no match. i_invalid  out  1  matched, V=0.
- d_req  in  1  data lookup request. d_vaddr  in  32  data virtual address. d_store  in  1  the access is a store.
- d_valid  out  1  data result valid. d_paddr  out  32  data physical address. d_refill  out  1  no match. d_invalid  out  1  matched, V=0.
- d_modified  out  1  store to a page with D=0.
- mcheck  out  1  multi-hit machine check. Present only with TLB_MULTIHIT_CHECK_EN.

## Operation

- Entry fields: vpn2[18:0], asid, g, then {pfn[19:0], c[2:0], d, v} for each of the even and odd pages. Page size is 4 KiB only.
- Match rule: entry.vpn2 == vaddr[31:13] && (entry.g || entry.asid == cur_asid). vaddr[12] selects the odd or even half. paddr = {pfn, vaddr[11:0]}.
- Unmapped: vaddr[31:30] == 2'b10 (kseg0/kseg1) → paddr = {3'b000, vaddr[28:0]}, no refill or invalid, valid.
- Multiple matches: the lowest index wins.
- tlbwi: tlbs[index] <= wr_entry. tlbwr: tlbs[random] <= wr_entry.
- tlbr: rd_entry <= tlbs[index].
- tlbp: matches wr_entry.vpn2 against cur_asid with the same rule.
- Random counter:
  - Reset value NUM_ENTRIES-1.
  - Decrements every cycle.
  - When random == wired, or wired ≥ NUM_ENTRIES-1, next value is NUM_ENTRIES-1.
  - wired_we forces NUM_ENTRIES-1 on the next cycle.
  - tlbwr uses the pre-update value of the same cycle.
- Reset: all entries zero, i.e. V=0, so every mapped address takes the invalid path, not refill, at vpn2 0. All outputs 0; random = NUM_ENTRIES-1.

## Timing

- Lookups: request at cycle N → result at N+1; valid = registered req. Outputs hold until the next request cycle. Lookups are fully pipelined, one per cycle per port.
- tlbp/tlbr: result at N+1 with a one-cycle prb_valid/rd_valid pulse.
- Write in cycle N is visible to lookups, probes and reads issued at N+1. Those issued at N see the old contents.
- Reset asserted mid-operation: valids deassert immediately (async), all pending results are discarded.

## Configuration

- TLB_MULTIHIT_CHECK_EN defined:
  - A lookup or probe matching ≥2 entries sets mcheck, sticky until reset.
  - The lowest index is still returned.
- TLB_MULTIHIT_CHECK_EN undefined: mcheck port and detection logic are absent.

## Structure

- Package tlb_pkg: tlb_entry_t and tlb_page_t packed structs, the KSEG decode constants, and the default NUM_ENTRIES/ASID_W.
- Sub-module tlb_match: combinational match of one vaddr/asid against all entries. Outputs hit, index and (with the macro) multi-hit. Instantiated three times: fetch, data, probe.

## Test plan

- Reset, then i_vaddr 0x00000000 → i_valid=1, i_invalid=1, i_refill=0. Reset, then d_vaddr 0x8000_1234 → d_paddr 0x0000_1234, no fault.
- tlbwi index 3, vpn2 0x00400>>1, asid 5, pfn1 0x12345 V=1 D=0. Fetch 0x0040_1ABC with cur_asid 5 → i_paddr 0x1234_5ABC. With cur_asid 6 → i_refill. Data store to the same address → d_modified.
- Same entry with g=1 → hits under every ASID. tlbp with a matching vpn2 → prb_index 3, prb_miss 0. Non-matching vpn2 → prb_miss 1.
- Set wired=4, then run 20 cycles → random visits 15..4 and wraps to 15. tlbwr writes the slot shown in that cycle. tlbr of that slot returns wr_entry.
- Write and lookup of the same address in the same cycle → old result. Repeat the lookup next cycle → new result.
- With TLB_MULTIHIT_CHECK_EN: identical entries at indices 2 and 7, then a lookup → paddr from index 2 and mcheck stays 1 until reset.

Source files
------------

// File: rtl/tlb_pkg.sv
// rtl/tlb_pkg.sv - shared TLB entry types, KSEG decode and default sizes
`timescale 1ns/1ps
package tlb_pkg;

  localparam int TLB_NUM_ENTRIES = 16;
  localparam int TLB_ASID_W      = 8;

  // kseg0/kseg1 share vaddr[31:30] == 2'b10 and bypass translation
  localparam logic [1:0] KSEG_UNMAPPED = 2'b10;

  typedef struct packed {
    logic [19:0] pfn;
    logic [2:0]  c;
    logic        d;
    logic        v;
  } tlb_page_t;

  typedef struct packed {
    logic [18:0]           vpn2;
    logic [TLB_ASID_W-1:0] asid;
    logic                  g;
    tlb_page_t             lo0;
    tlb_page_t             lo1;
  } tlb_entry_t;

  function automatic logic isUnmapped(input logic [31:0] vaddr);
    return vaddr[31:30] == KSEG_UNMAPPED;
  endfunction

endpackage

// File: rtl/tlb_match.sv
// rtl/tlb_match.sv - combinational VPN2/ASID match across all entries, lowest index wins
// Multi-hit output exists only when TLB_MULTIHIT_CHECK_EN is defined.
`timescale 1ns/1ps
module tlb_match
  import tlb_pkg::*;
#(
  parameter int NUM_ENTRIES = TLB_NUM_ENTRIES,
  parameter int ASID_W      = TLB_ASID_W,
  parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  tlb_entry_t        entries [NUM_ENTRIES],
  input  logic [18:0]       vpn2,
  input  logic [ASID_W-1:0] asid,
  output logic              hit,
  output logic [IDX_W-1:0]  idx
`ifdef TLB_MULTIHIT_CHECK_EN
  , output logic            multi
`endif
);

  always_comb begin
    hit = 1'b0;
    idx = '0;
`ifdef TLB_MULTIHIT_CHECK_EN
    multi = 1'b0;
`endif
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (entries[i].vpn2 == vpn2 && (entries[i].g || entries[i].asid == asid)) begin
        if (!hit) idx = IDX_W'(i);
`ifdef TLB_MULTIHIT_CHECK_EN
        multi = multi | hit;
`endif
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tlb_assoc.sv
// rtl/tlb_assoc.sv - fully associative MIPS32 joint TLB with fetch/data ports, tlbwi/tlbwr/tlbr/tlbp
// Optional sticky multi-hit machine check under TLB_MULTIHIT_CHECK_EN.
`timescale 1ns/1ps
module tlb_assoc
  import tlb_pkg::*;
#(
  parameter int NUM_ENTRIES = TLB_NUM_ENTRIES,
  parameter int ASID_W      = TLB_ASID_W,
  parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic              clk,
  input  logic              rst,
  input  tlb_entry_t        wr_entry,
  input  logic [ASID_W-1:0] cur_asid,
  input  logic [IDX_W-1:0]  index,
  input  logic [IDX_W-1:0]  wired,
  input  logic              wired_we,
  input  logic              tlbwi,
  input  logic              tlbwr,
  input  logic              tlbr,
  input  logic              tlbp,
  output logic [IDX_W-1:0]  random,
  output logic              rd_valid,
  output tlb_entry_t        rd_entry,
  output logic              prb_valid,
  output logic              prb_miss,
  output logic [IDX_W-1:0]  prb_index,
  input  logic              i_req,
  input  logic [31:0]       i_vaddr,
  output logic              i_valid,
  output logic [31:0]       i_paddr,
  output logic              i_refill,
  output logic              i_invalid,
  input  logic              d_req,
  input  logic [31:0]       d_vaddr,
  input  logic              d_store,
  output logic              d_valid,
  output logic [31:0]       d_paddr,
  output logic              d_refill,
  output logic              d_invalid,
  output logic              d_modified
`ifdef TLB_MULTIHIT_CHECK_EN
  , output logic            mcheck
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

  tlb_entry_t tlbs [NUM_ENTRIES];

  logic             iHit, dHit, pHit;
  logic [IDX_W-1:0] iIdx, dIdx, pIdx;
`ifdef TLB_MULTIHIT_CHECK_EN
  logic             iMulti, dMulti, pMulti;
`endif

  tlb_match #(.NUM_ENTRIES(NUM_ENTRIES), .ASID_W(ASID_W), .IDX_W(IDX_W)) uFetchMatch (
    .entries(tlbs), .vpn2(i_vaddr[31:13]), .asid(cur_asid), .hit(iHit), .idx(iIdx)
`ifdef TLB_MULTIHIT_CHECK_EN
    , .multi(iMulti)
`endif
  );

  tlb_match #(.NUM_ENTRIES(NUM_ENTRIES), .ASID_W(ASID_W), .IDX_W(IDX_W)) uDataMatch (
    .entries(tlbs), .vpn2(d_vaddr[31:13]), .asid(cur_asid), .hit(dHit), .idx(dIdx)
`ifdef TLB_MULTIHIT_CHECK_EN
    , .multi(dMulti)
`endif
  );

  tlb_match #(.NUM_ENTRIES(NUM_ENTRIES), .ASID_W(ASID_W), .IDX_W(IDX_W)) uProbeMatch (
    .entries(tlbs), .vpn2(wr_entry.vpn2), .asid(cur_asid), .hit(pHit), .idx(pIdx)
`ifdef TLB_MULTIHIT_CHECK_EN
    , .multi(pMulti)
`endif
  );

  logic      iUnmapped, dUnmapped;
  tlb_page_t iPage, dPage;

  assign iUnmapped = isUnmapped(i_vaddr);
  assign dUnmapped = isUnmapped(d_vaddr);
  assign iPage     = i_vaddr[12] ? tlbs[iIdx].lo1 : tlbs[iIdx].lo0;
  assign dPage     = d_vaddr[12] ? tlbs[dIdx].lo1 : tlbs[dIdx].lo0;

  // tlbwr targets the Random value visible in the same cycle, before it steps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) tlbs[i] <= '0;
    end else if (tlbwi) begin
      tlbs[index] <= wr_entry;
    end else if (tlbwr) begin
      tlbs[random] <= wr_entry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                 random <= LAST_IDX;
    else if (wired_we || random == wired || wired >= LAST_IDX) random <= LAST_IDX;
    else                                                     random <= random - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid  <= 1'b0;
      rd_entry  <= '0;
      prb_valid <= 1'b0;
      prb_miss  <= 1'b0;
      prb_index <= '0;
    end else begin
      rd_valid  <= tlbr;
      prb_valid <= tlbp;
      if (tlbr) rd_entry <= tlbs[index];
      if (tlbp) begin
        prb_miss  <= !pHit;
        prb_index <= pIdx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_valid   <= 1'b0;
      i_paddr   <= '0;
      i_refill  <= 1'b0;
      i_invalid <= 1'b0;
    end else begin
      i_valid <= i_req;
      if (i_req) begin
        i_paddr   <= iUnmapped ? {3'b000, i_vaddr[28:0]} :
                     iHit      ? {iPage.pfn, i_vaddr[11:0]} : 32'h0;
        i_refill  <= !iUnmapped && !iHit;
        i_invalid <= !iUnmapped && iHit && !iPage.v;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_valid    <= 1'b0;
      d_paddr    <= '0;
      d_refill   <= 1'b0;
      d_invalid  <= 1'b0;
      d_modified <= 1'b0;
    end else begin
      d_valid <= d_req;
      if (d_req) begin
        d_paddr    <= dUnmapped ? {3'b000, d_vaddr[28:0]} :
                      dHit      ? {dPage.pfn, d_vaddr[11:0]} : 32'h0;
        d_refill   <= !dUnmapped && !dHit;
        d_invalid  <= !dUnmapped && dHit && !dPage.v;
        d_modified <= !dUnmapped && dHit && dPage.v && !dPage.d && d_store;
      end
    end
  end

`ifdef TLB_MULTIHIT_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcheck <= 1'b0;
    end else if ((i_req && !iUnmapped && iMulti) || (d_req && !dUnmapped && dMulti) ||
                 (tlbp && pMulti)) begin
      mcheck <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_tlb_assoc.sv
// tb/tb_tlb_assoc.sv - randomized self-checking bench for tlb_assoc against a flat-array TLB model
`timescale 1ns/1ps
module tb_tlb_assoc;
  import tlb_pkg::*;

  localparam int N  = 16;
  localparam int IW = 4;

  logic            clk, rst;
  tlb_entry_t      wr_entry, rd_entry;
  logic [7:0]      cur_asid;
  logic [IW-1:0]   index, wired, random, prb_index;
  logic            wired_we, tlbwi, tlbwr, tlbr, tlbp;
  logic            rd_valid, prb_valid, prb_miss;
  logic            i_req, i_valid, i_refill, i_invalid;
  logic [31:0]     i_vaddr, i_paddr;
  logic            d_req, d_store, d_valid, d_refill, d_invalid, d_modified;
  logic [31:0]     d_vaddr, d_paddr;
`ifdef TLB_MULTIHIT_CHECK_EN
  logic            mcheck;
`endif

  tlb_entry_t model [N];
  int asserts = 0;
  int fails   = 0;

  tlb_assoc #(.NUM_ENTRIES(N), .ASID_W(8)) dut (
    .clk(clk), .rst(rst), .wr_entry(wr_entry), .cur_asid(cur_asid), .index(index),
    .wired(wired), .wired_we(wired_we), .tlbwi(tlbwi), .tlbwr(tlbwr), .tlbr(tlbr), .tlbp(tlbp),
    .random(random), .rd_valid(rd_valid), .rd_entry(rd_entry), .prb_valid(prb_valid),
    .prb_miss(prb_miss), .prb_index(prb_index),
    .i_req(i_req), .i_vaddr(i_vaddr), .i_valid(i_valid), .i_paddr(i_paddr),
    .i_refill(i_refill), .i_invalid(i_invalid),
    .d_req(d_req), .d_vaddr(d_vaddr), .d_store(d_store), .d_valid(d_valid), .d_paddr(d_paddr),
    .d_refill(d_refill), .d_invalid(d_invalid), .d_modified(d_modified)
`ifdef TLB_MULTIHIT_CHECK_EN
    , .mcheck(mcheck)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic tlb_entry_t mkEntry(input logic [18:0] vpn2, input logic [7:0] asid,
                                         input logic g, input logic [19:0] pfn0, input logic v0,
                                         input logic d0, input logic [19:0] pfn1, input logic v1,
                                         input logic d1);
    tlb_entry_t e;
    e = '0;
    e.vpn2 = vpn2; e.asid = asid; e.g = g;
    e.lo0.pfn = pfn0; e.lo0.v = v0; e.lo0.d = d0;
    e.lo1.pfn = pfn1; e.lo1.v = v1; e.lo1.d = d1;
    return e;
  endfunction

  function automatic tlb_entry_t randEntry(input logic [18:0] vpn2);
    tlb_entry_t e;
    e = mkEntry(vpn2, 8'($urandom % 4), ($urandom % 4) == 0,
                20'($urandom), ($urandom % 4) != 0, 1'($urandom),
                20'($urandom), ($urandom % 4) != 0, 1'($urandom));
    e.lo0.c = 3'($urandom);
    e.lo1.c = 3'($urandom);
    return e;
  endfunction

  // Reference: first matching entry scanning from index 0
  function automatic void refLookup(input logic [31:0] va, input logic [7:0] asid,
                                    input logic st, output logic [31:0] pa,
                                    output logic refill, output logic inval, output logic modi);
    tlb_page_t pg;
    pa = 32'h0; refill = 1'b0; inval = 1'b0; modi = 1'b0;
    if (va[31:30] == 2'b10) begin
      pa = {3'b000, va[28:0]};
      return;
    end
    for (int i = 0; i < N; i++) begin
      if (model[i].vpn2 == va[31:13] && (model[i].g || model[i].asid == asid)) begin
        pg    = va[12] ? model[i].lo1 : model[i].lo0;
        pa    = {pg.pfn, va[11:0]};
        inval = !pg.v;
        modi  = st && pg.v && !pg.d;
        return;
      end
    end
    refill = 1'b1;
  endfunction

  function automatic void refProbe(input logic [18:0] vpn2, input logic [7:0] asid,
                                   output logic miss, output logic [IW-1:0] idx);
    miss = 1'b1; idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (model[i].vpn2 == vpn2 && (model[i].g || model[i].asid == asid)) begin
        miss = 1'b0; idx = IW'(i);
      end
  endfunction

  task automatic clearModel;
    for (int i = 0; i < N; i++) model[i] = '0;
  endtask

  task automatic doWrite(input int idx, input tlb_entry_t e);
    index = IW'(idx); wr_entry = e; tlbwi = 1'b1;
    tick;
    tlbwi = 1'b0;
    model[idx] = e;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick; tick;
    asserts++;
    if ({i_valid, i_refill, i_invalid, i_paddr, d_valid, d_refill, d_invalid, d_modified, d_paddr,
         rd_valid, prb_valid, prb_miss, prb_index} !== '0) begin
      fails++; $display("FAIL reset_outputs: got nonzero outputs i_valid=%b d_valid=%b rd_valid=%b prb_valid=%b, required all 0",
                        i_valid, d_valid, rd_valid, prb_valid);
    end
    asserts++;
    if (random !== 4'd15) begin fails++; $display("FAIL reset_random: got %0d required 15", random); end
    rst = 1'b0;
    clearModel();
    cur_asid = 8'd0;
    i_req = 1'b1; i_vaddr = 32'h0000_0000;
    d_req = 1'b1; d_vaddr = 32'h8000_1234; d_store = 1'b0;
    tick;
    i_req = 1'b0; d_req = 1'b0;
    asserts++;
    if ({i_valid, i_refill, i_invalid} !== 3'b101) begin
      fails++; $display("FAIL reset_fetch_invalid: got v/r/i=%b required 101", {i_valid, i_refill, i_invalid});
    end
    asserts++;
    if ({d_valid, d_refill, d_invalid, d_modified, d_paddr} !== {4'b1000, 32'h0000_1234}) begin
      fails++; $display("FAIL reset_kseg_data: got flags=%b paddr=%h required 1000 00001234",
                        {d_valid, d_refill, d_invalid, d_modified}, d_paddr);
    end
  endtask

  task automatic test_mapped;
    doWrite(3, mkEntry(19'h00200, 8'd5, 1'b0, 20'h0, 1'b0, 1'b0, 20'h12345, 1'b1, 1'b0));
    cur_asid = 8'd5; i_req = 1'b1; i_vaddr = 32'h0040_1ABC;
    tick;
    asserts++;
    if ({i_valid, i_refill, i_invalid, i_paddr} !== {3'b100, 32'h1234_5ABC}) begin
      fails++; $display("FAIL mapped_hit: got flags=%b paddr=%h required 100 12345abc",
                        {i_valid, i_refill, i_invalid}, i_paddr);
    end
    cur_asid = 8'd6;
    tick;
    asserts++;
    if ({i_valid, i_refill} !== 2'b11) begin
      fails++; $display("FAIL mapped_asid_miss: got valid/refill=%b required 11", {i_valid, i_refill});
    end
    i_req = 1'b0;
    cur_asid = 8'd5; d_req = 1'b1; d_vaddr = 32'h0040_1ABC; d_store = 1'b1;
    tick;
    d_req = 1'b0; d_store = 1'b0;
    asserts++;
    if ({d_valid, d_refill, d_invalid, d_modified, d_paddr} !== {4'b1001, 32'h1234_5ABC}) begin
      fails++; $display("FAIL mapped_store_modified: got flags=%b paddr=%h required 1001 12345abc",
                        {d_valid, d_refill, d_invalid, d_modified}, d_paddr);
    end
  endtask

  task automatic test_global_probe;
    doWrite(3, mkEntry(19'h00200, 8'd5, 1'b1, 20'h0, 1'b0, 1'b0, 20'h12345, 1'b1, 1'b0));
    i_vaddr = 32'h0040_1ABC;
    for (int k = 0; k < 4; k++) begin
      cur_asid = 8'($urandom); i_req = 1'b1;
      tick;
      asserts++;
      if ({i_valid, i_refill, i_paddr} !== {2'b10, 32'h1234_5ABC}) begin
        fails++; $display("FAIL global_hit asid=%0d: got v/r=%b paddr=%h required 10 12345abc",
                          cur_asid, {i_valid, i_refill}, i_paddr);
      end
    end
    i_req = 1'b0;
    wr_entry = mkEntry(19'h00200, 8'd9, 1'b0, 20'h0, 1'b0, 1'b0, 20'h0, 1'b0, 1'b0);
    cur_asid = 8'd77; tlbp = 1'b1;
    tick;
    tlbp = 1'b0;
    asserts++;
    if ({prb_valid, prb_miss, prb_index} !== {2'b10, 4'd3}) begin
      fails++; $display("FAIL probe_hit: got v/miss=%b idx=%0d required 10 idx 3",
                        {prb_valid, prb_miss}, prb_index);
    end
    tick;
    asserts++;
    if (prb_valid !== 1'b0) begin fails++; $display("FAIL probe_pulse: got prb_valid=%b required 0", prb_valid); end
    wr_entry.vpn2 = 19'h01234; tlbp = 1'b1;
    tick;
    tlbp = 1'b0;
    asserts++;
    if ({prb_valid, prb_miss} !== 2'b11) begin
      fails++; $display("FAIL probe_miss: got v/miss=%b required 11", {prb_valid, prb_miss});
    end
  endtask

  task automatic test_random_tlbwr;
    tlb_entry_t eR;
    int slot;
    eR = randEntry(19'h3AAAA);
    wired = 4'd4; wired_we = 1'b1;
    tick;
    wired_we = 1'b0;
    slot = 15 - (5 % 12);
    for (int k = 0; k < 20; k++) begin
      asserts++;
      if (random !== 4'(15 - (k % 12))) begin
        fails++; $display("FAIL random_step%0d: got %0d required %0d", k, random, 15 - (k % 12));
      end
      tlbwr = (k == 5);
      if (k == 5) wr_entry = eR;
      tick;
    end
    tlbwr = 1'b0;
    model[slot] = eR;
    index = IW'(slot); tlbr = 1'b1;
    tick;
    tlbr = 1'b0;
    asserts++;
    if (rd_valid !== 1'b1 || rd_entry !== eR) begin
      fails++; $display("FAIL tlbr_after_tlbwr: got valid=%b entry=%h required 1 %h", rd_valid, rd_entry, eR);
    end
    tick;
    asserts++;
    if (rd_valid !== 1'b0) begin fails++; $display("FAIL tlbr_pulse: got rd_valid=%b required 0", rd_valid); end
  endtask

  task automatic test_same_cycle;
    tlb_entry_t eNew;
    eNew = mkEntry(19'h00200, 8'd5, 1'b1, 20'h0, 1'b0, 1'b0, 20'h0ABCD, 1'b1, 1'b1);
    index = 4'd3; wr_entry = eNew; tlbwi = 1'b1;
    i_req = 1'b1; i_vaddr = 32'h0040_1ABC;
    tick;
    tlbwi = 1'b0;
    model[3] = eNew;
    asserts++;
    if (i_paddr !== 32'h1234_5ABC) begin
      fails++; $display("FAIL same_cycle_old: got %h required 12345abc", i_paddr);
    end
    tick;
    i_req = 1'b0;
    asserts++;
    if (i_paddr !== 32'h0ABC_DABC) begin
      fails++; $display("FAIL same_cycle_new: got %h required 0abcdabc", i_paddr);
    end
  endtask

  task automatic test_random_lookups;
    logic [31:0]   ePa;
    logic          eRef, eInv, eMod, eMiss;
    logic [IW-1:0] eIdx;
    logic [7:0]    asid;
    for (int it = 0; it < 200; it++) begin
      if ($urandom % 3 == 0) doWrite(int'($urandom % N), randEntry(19'h100 + 19'($urandom % 8)));
      asid = 8'($urandom % 4);
      cur_asid = asid;
      i_vaddr = ($urandom % 4 == 0) ? {2'b10, 30'($urandom)} : {19'h100 + 19'($urandom % 9), 13'($urandom)};
      d_vaddr = ($urandom % 4 == 0) ? {2'b10, 30'($urandom)} : {19'h100 + 19'($urandom % 9), 13'($urandom)};
      d_store = 1'($urandom);
      wr_entry.vpn2 = 19'h100 + 19'($urandom % 9);
      i_req = 1'b1; d_req = 1'b1; tlbp = 1'b1;
      tick;
      i_req = 1'b0; d_req = 1'b0; tlbp = 1'b0;
      refLookup(i_vaddr, asid, 1'b0, ePa, eRef, eInv, eMod);
      asserts++;
      if ({i_valid, i_refill, i_invalid, i_paddr} !== {1'b1, eRef, eInv, ePa}) begin
        fails++; $display("FAIL rand_fetch va=%h: got v/r/i=%b pa=%h required 1%b%b pa=%h",
                          i_vaddr, {i_valid, i_refill, i_invalid}, i_paddr, eRef, eInv, ePa);
      end
      refLookup(d_vaddr, asid, d_store, ePa, eRef, eInv, eMod);
      asserts++;
      if ({d_valid, d_refill, d_invalid, d_modified, d_paddr} !== {1'b1, eRef, eInv, eMod, ePa}) begin
        fails++; $display("FAIL rand_data va=%h: got v/r/i/m=%b pa=%h required 1%b%b%b pa=%h",
                          d_vaddr, {d_valid, d_refill, d_invalid, d_modified}, d_paddr, eRef, eInv, eMod, ePa);
      end
      refProbe(wr_entry.vpn2, asid, eMiss, eIdx);
      asserts++;
      if ({prb_valid, prb_miss} !== {1'b1, eMiss} || (!eMiss && prb_index !== eIdx)) begin
        fails++; $display("FAIL rand_probe vpn2=%h: got v/miss=%b idx=%0d required 1%b idx=%0d",
                          wr_entry.vpn2, {prb_valid, prb_miss}, prb_index, eMiss, eIdx);
      end
    end
  endtask

  task automatic test_reset_midop;
    i_req = 1'b1; i_vaddr = 32'h9000_0040;
    tick;
    i_req = 1'b0;
    #2 rst = 1'b1;
    #1;
    asserts++;
    if ({i_valid, random} !== {1'b0, 4'd15}) begin
      fails++; $display("FAIL async_reset: got i_valid=%b random=%0d required 0 15", i_valid, random);
    end
    tick;
    rst = 1'b0;
    clearModel();
    wired = 4'd0;
  endtask

`ifdef TLB_MULTIHIT_CHECK_EN
  task automatic test_multihit;
    cur_asid = 8'd1;
    doWrite(2, mkEntry(19'h00055, 8'd1, 1'b0, 20'hAAAAA, 1'b1, 1'b1, 20'h0, 1'b0, 1'b0));
    doWrite(7, mkEntry(19'h00055, 8'd1, 1'b0, 20'h77777, 1'b1, 1'b1, 20'h0, 1'b0, 1'b0));
    asserts++;
    if (mcheck !== 1'b0) begin fails++; $display("FAIL mcheck_before: got %b required 0", mcheck); end
    i_req = 1'b1; i_vaddr = 32'h000A_A123;
    tick;
    i_req = 1'b0;
    asserts++;
    if ({i_paddr, mcheck} !== {32'hAAAA_A123, 1'b1}) begin
      fails++; $display("FAIL multihit_lookup: got pa=%h mcheck=%b required aaaaa123 1", i_paddr, mcheck);
    end
    tick; tick; tick;
    asserts++;
    if (mcheck !== 1'b1) begin fails++; $display("FAIL mcheck_sticky: got %b required 1", mcheck); end
    rst = 1'b1;
    #1;
    asserts++;
    if (mcheck !== 1'b0) begin fails++; $display("FAIL mcheck_reset: got %b required 0", mcheck); end
    tick;
    rst = 1'b0;
    clearModel();
  endtask
`endif

  initial begin
    rst = 1'b1; wr_entry = '0; cur_asid = '0; index = '0; wired = '0; wired_we = 1'b0;
    tlbwi = 1'b0; tlbwr = 1'b0; tlbr = 1'b0; tlbp = 1'b0;
    i_req = 1'b0; i_vaddr = '0; d_req = 1'b0; d_vaddr = '0; d_store = 1'b0;
    test_reset();
    test_mapped();
    test_global_probe();
    test_random_tlbwr();
    test_same_cycle();
    test_random_lookups();
    test_reset_midop();
`ifdef TLB_MULTIHIT_CHECK_EN
    test_multihit();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
